// File: rtl/snell_pkg.sv
// Shared definitions for the Snell index solver: FSM state encoding, default
// parameter values and the product-width / latency derivations.
// Optional build macro: SNELL_ROUND_EN (one extra quotient bit, round half-up).
package snell_pkg;

  localparam int IDX_W_DEF    = 8;
  localparam int IDX_FRAC_DEF = 4;
  localparam int ANG_W_DEF    = 7;
  localparam int SIN_FRAC_DEF = 8;

  localparam int ANG_MAX      = 90;
  localparam int LUT_DEPTH    = ANG_MAX + 1;

  // pi scaled by 2^30, used to build the sine table at elaboration
  localparam longint PI_Q30   = 64'sd3373259426;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOOK2 = 3'd1,
    LOOK1 = 3'd2,
    MUL   = 3'd3,
    DIV   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Exact width of n2 * sin(theta2)
  function automatic int calc_pw(input int idx_w, input int sin_frac);
    return idx_w + sin_frac + 1;
  endfunction

  // Number of quotient bits produced, one per DIV cycle
  function automatic int calc_div_bits(input int idx_w, input int sin_frac);
`ifdef SNELL_ROUND_EN
    return calc_pw(idx_w, sin_frac) + 1;
`else
    return calc_pw(idx_w, sin_frac);
`endif
  endfunction

  // Accept edge to out_valid: LOOK2, LOOK1, MUL, DIV bits, DONE format cycle
  function automatic int calc_latency(input int idx_w, input int sin_frac);
    return calc_div_bits(idx_w, sin_frac) + 4;
  endfunction

endpackage

// File: rtl/snell_sine_lut.sv
// Sine table for integer degrees 0..90, values round(sin(d) * 2^SIN_FRAC),
// built at elaboration with a fixed-point Taylor series. Output is registered,
// so data appears one cycle after the address is presented.
module snell_sine_lut import snell_pkg::*; #(
  parameter int SIN_FRAC = SIN_FRAC_DEF
) (
  input  logic                clk,
  input  logic [6:0]          addr_i,
  output logic [SIN_FRAC:0]   sin_o
);

  localparam int SW = SIN_FRAC + 1;

  function automatic logic [LUT_DEPTH*SW-1:0] build_table();
    logic [LUT_DEPTH*SW-1:0] tbl;
    longint x;
    longint term;
    longint acc;
    longint v;
    tbl = '0;
    for (int d = 0; d < LUT_DEPTH; d++) begin
      x    = (longint'(d) * PI_Q30) / 64'sd180;
      term = x;
      acc  = x;
      for (int k = 1; k <= 8; k++) begin
        term = (term * x) >>> 30;
        term = (term * x) >>> 30;
        term = -(term / longint'((2 * k) * (2 * k + 1)));
        acc  = acc + term;
      end
      v = ((acc <<< SIN_FRAC) + (64'sd1 <<< 29)) >>> 30;
      // sin(90) must be exactly 1.0 regardless of series error
      if (d == ANG_MAX) v = 64'sd1 <<< SIN_FRAC;
      tbl[d*SW +: SW] = v[SW-1:0];
    end
    return tbl;
  endfunction

  localparam logic [LUT_DEPTH*SW-1:0] TABLE = build_table();

  logic [6:0]    idx;
  logic [SW-1:0] sin_q;

  assign idx   = (addr_i > 7'(ANG_MAX)) ? 7'(ANG_MAX) : addr_i;
  assign sin_o = sin_q;

  // Registered table read
  always_ff @(posedge clk) begin
    sin_q <= TABLE[int'(idx)*SW +: SW];
  end

endmodule

// File: rtl/snell_index_solver.sv
// Computes n1 = n2 * sin(theta2) / sin(theta1) in unsigned fixed point with a
// shared sine table and a bit-serial restoring divider.
// Optional build macro: SNELL_ROUND_EN -- one extra quotient bit, round half-up.
//
// state | meaning
// IDLE  | ready for operands
// LOOK2 | table addressed with theta2
// LOOK1 | sin(theta2) captured, table addressed with theta1
// MUL   | sin(theta1) captured, dividend = n2 * sin(theta2)
// DIV   | one quotient bit per cycle, MSB first
// DONE  | result formatted, then held until out_ready
module snell_index_solver import snell_pkg::*; #(
  parameter int IDX_W    = IDX_W_DEF,
  parameter int IDX_FRAC = IDX_FRAC_DEF,
  parameter int ANG_W    = ANG_W_DEF,
  parameter int SIN_FRAC = SIN_FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] n2,
  input  logic [ANG_W-1:0] theta1,
  input  logic [ANG_W-1:0] theta2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] n1,
  output logic             div_zero,
  output logic             sat
);

  localparam int PW = calc_pw(IDX_W, SIN_FRAC);
  localparam int DW = calc_div_bits(IDX_W, SIN_FRAC);
  localparam int SW = SIN_FRAC + 1;
  localparam int CW = $clog2(DW);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] n2_q, n2_d;
  logic [6:0]       th1_q, th1_d, th2_q, th2_d;
  logic [SW-1:0]    sin2_q, sin2_d, sin1_q, sin1_d, rem_q, rem_d;
  logic [DW-1:0]    dq_q, dq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] n1_q, n1_d;
  logic             dz_q, dz_d, sat_q, sat_d, ov_q, ov_d;

  logic [6:0]       lut_addr;
  logic [SW-1:0]    lut_sin;
  logic             accept;
  logic [SW:0]      trial;
  logic             qbit;
  logic [PW-1:0]    prod;
  logic [DW-1:0]    q_fin;
  logic             q_ovf;
`ifdef SNELL_ROUND_EN
  logic [DW:0]      q_inc;
`endif

  function automatic logic [6:0] clamp_ang(input logic [ANG_W-1:0] a);
    if (a > ANG_W'(ANG_MAX)) return 7'(ANG_MAX);
    return 7'(a);
  endfunction

  snell_sine_lut #(.SIN_FRAC(SIN_FRAC)) u_lut (
    .clk    (clk),
    .addr_i (lut_addr),
    .sin_o  (lut_sin)
  );

  assign accept    = (state_q == IDLE) && in_valid;
  assign out_valid = ov_q;
  assign n1        = n1_q;
  assign div_zero  = dz_q;
  assign sat       = sat_q;

  // Divider step, dividend product and final quotient shaping
  always_comb begin
    trial = {rem_q, dq_q[DW-1]};
    qbit  = (trial >= {1'b0, sin1_q});
    prod  = PW'(n2_q) * PW'(sin2_q);
`ifdef SNELL_ROUND_EN
    q_inc = {1'b0, dq_q} + (DW+1)'(1);
    q_fin = q_inc[DW:1];
`else
    q_fin = dq_q;
`endif
    q_ovf = |q_fin[DW-1:IDX_W];
  end

  // Next state, in_ready and table address selection
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    lut_addr = th1_q;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = LOOK2;
      end
      LOOK2: begin
        lut_addr = th2_q;
        state_d  = LOOK1;
      end
      LOOK1: state_d = MUL;
      MUL:   state_d = DIV;
      DIV:   if (cnt_q == '0) state_d = DONE;
      DONE:  if (ov_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    n2_d   = n2_q;
    th1_d  = th1_q;
    th2_d  = th2_q;
    sin2_d = sin2_q;
    sin1_d = sin1_q;
    rem_d  = rem_q;
    dq_d   = dq_q;
    cnt_d  = cnt_q;
    n1_d   = n1_q;
    dz_d   = dz_q;
    sat_d  = sat_q;
    ov_d   = ov_q;
    if (accept) begin
      n2_d  = n2;
      th1_d = clamp_ang(theta1);
      th2_d = clamp_ang(theta2);
    end
    unique case (state_q)
      LOOK1: sin2_d = lut_sin;
      MUL: begin
        sin1_d = lut_sin;
        rem_d  = '0;
        cnt_d  = CW'(DW - 1);
`ifdef SNELL_ROUND_EN
        dq_d   = {prod, 1'b0};
`else
        dq_d   = prod;
`endif
      end
      DIV: begin
        rem_d = qbit ? SW'(trial - {1'b0, sin1_q}) : trial[SW-1:0];
        dq_d  = {dq_q[DW-2:0], qbit};
        cnt_d = cnt_q - CW'(1);
      end
      DONE: begin
        if (!ov_q) begin
          ov_d = 1'b1;
          if (th1_q == '0) begin
            n1_d  = '1;
            dz_d  = 1'b1;
            sat_d = 1'b0;
          end else if (q_ovf) begin
            n1_d  = '1;
            dz_d  = 1'b0;
            sat_d = 1'b1;
          end else begin
            // integer field then fraction field of the quotient
            n1_d  = {q_fin[IDX_W-1:IDX_FRAC], q_fin[IDX_FRAC-1:0]};
            dz_d  = 1'b0;
            sat_d = 1'b0;
          end
        end else if (out_ready) begin
          ov_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      n2_q   <= '0;
      th1_q  <= '0;
      th2_q  <= '0;
      sin2_q <= '0;
      sin1_q <= '0;
      rem_q  <= '0;
      dq_q   <= '0;
      cnt_q  <= '0;
      n1_q   <= '0;
      dz_q   <= 1'b0;
      sat_q  <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      n2_q   <= n2_d;
      th1_q  <= th1_d;
      th2_q  <= th2_d;
      sin2_q <= sin2_d;
      sin1_q <= sin1_d;
      rem_q  <= rem_d;
      dq_q   <= dq_d;
      cnt_q  <= cnt_d;
      n1_q   <= n1_d;
      dz_q   <= dz_d;
      sat_q  <= sat_d;
      ov_q   <= ov_d;
    end
  end

endmodule

// File: tb/tb_snell_index_solver.sv
// Self-checking bench for snell_index_solver against a real-arithmetic model.
module tb_snell_index_solver;

  localparam int IDX_W    = 8;
  localparam int SIN_FRAC = 8;
  localparam int ANG_W    = 7;
  localparam int PW       = IDX_W + SIN_FRAC + 1;
`ifdef SNELL_ROUND_EN
  localparam int LAT      = PW + 5;
  localparam bit ROUND    = 1'b1;
`else
  localparam int LAT      = PW + 4;
  localparam bit ROUND    = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] n2;
  logic [ANG_W-1:0] theta1;
  logic [ANG_W-1:0] theta2;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] n1;
  logic             div_zero;
  logic             sat;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  snell_index_solver dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n2        (n2),
    .theta1    (theta1),
    .theta2    (theta2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n1        (n1),
    .div_zero  (div_zero),
    .sat       (sat)
  );

  function automatic int ref_sin(input int d);
    real r;
    if (d == 90) return (1 << SIN_FRAC);
    r = $sin(real'(d) * 3.14159265358979323846 / 180.0) * real'(1 << SIN_FRAC);
    return $rtoi(r + 0.5);
  endfunction

  function automatic void model(input int a, input int t1, input int t2,
                                output int e_n1, output bit e_dz, output bit e_sat);
    int s1, s2;
    longint p, q;
    s1 = ref_sin((t1 > 90) ? 90 : t1);
    s2 = ref_sin((t2 > 90) ? 90 : t2);
    p  = longint'(a) * longint'(s2);
    e_dz  = 1'b0;
    e_sat = 1'b0;
    if (s1 == 0) begin
      e_n1 = (1 << IDX_W) - 1;
      e_dz = 1'b1;
    end else begin
      if (ROUND) q = (2 * p + s1) / (2 * longint'(s1));
      else       q = p / s1;
      if (q >= (1 << IDX_W)) begin
        e_n1  = (1 << IDX_W) - 1;
        e_sat = 1'b1;
      end else begin
        e_n1 = int'(q);
      end
    end
  endfunction

  // Waits for in_ready, launches one operation and waits for out_valid.
  task automatic do_op(input int a, input int t1, input int t2,
                       output int r_n1, output bit r_dz, output bit r_sat,
                       output int r_lat, output bit r_to);
    int w;
    r_to = 1'b0; r_n1 = 0; r_dz = 1'b0; r_sat = 1'b0; r_lat = 0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      r_to = 1'b1;
      return;
    end
    in_valid = 1'b1;
    n2       = IDX_W'(a);
    theta1   = ANG_W'(t1);
    theta2   = ANG_W'(t2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && r_lat < 200) begin
      @(posedge clk); #1; r_lat++;
    end
    if (!out_valid) r_to = 1'b1;
    r_n1  = int'(n1);
    r_dz  = div_zero;
    r_sat = sat;
  endtask

  task automatic release_result(input int delay);
    repeat (delay) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    n2 = '0; theta1 = '0; theta2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    tests_run++; if (n1 !== 8'h00) begin tests_failed++; $display("FAIL reset n1 got %h want 00", n1); end
    tests_run++; if (div_zero !== 1'b0) begin tests_failed++; $display("FAIL reset div_zero got %b want 0", div_zero); end
    tests_run++; if (sat !== 1'b0) begin tests_failed++; $display("FAIL reset sat got %b want 0", sat); end
  endtask

  task automatic test_directed();
    int ca[6] = '{'h18, 'h10, 'h10, 'hF0, 'hF0, 'h37};
    int c1[6] = '{30,   30,   0,    30,   120,  90};
    int c2[6] = '{30,   90,   45,   90,   90,   0};
    int r_n1, r_lat, e_n1;
    bit r_dz, r_sat, r_to, e_dz, e_sat;
    for (int i = 0; i < 6; i++) begin
      model(ca[i], c1[i], c2[i], e_n1, e_dz, e_sat);
      do_op(ca[i], c1[i], c2[i], r_n1, r_dz, r_sat, r_lat, r_to);
      tests_run++;
      if (r_to) begin tests_failed++; $display("FAIL directed %0d timeout got no out_valid want out_valid", i); end
      tests_run++; if (r_n1 !== e_n1) begin tests_failed++; $display("FAIL directed %0d n1 got %h want %h", i, r_n1, e_n1); end
      tests_run++; if (r_dz !== e_dz) begin tests_failed++; $display("FAIL directed %0d div_zero got %b want %b", i, r_dz, e_dz); end
      tests_run++; if (r_sat !== e_sat) begin tests_failed++; $display("FAIL directed %0d sat got %b want %b", i, r_sat, e_sat); end
      tests_run++; if (r_lat !== LAT) begin tests_failed++; $display("FAIL directed %0d latency got %0d want %0d", i, r_lat, LAT); end
      release_result(0);
    end
  endtask

  task automatic test_stall();
    int r_n1, r_lat, e_n1;
    bit r_dz, r_sat, r_to, e_dz, e_sat;
    model('h18, 30, 30, e_n1, e_dz, e_sat);
    do_op('h18, 30, 30, r_n1, r_dz, r_sat, r_lat, r_to);
    tests_run++;
    if (r_to) begin tests_failed++; $display("FAIL stall timeout got no out_valid want out_valid"); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall out_valid cyc %0d got %b want 1", c, out_valid); end
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall in_ready cyc %0d got %b want 0", c, in_ready); end
      tests_run++; if (int'(n1) !== e_n1) begin tests_failed++; $display("FAIL stall n1 cyc %0d got %h want %h", c, n1, e_n1); end
      tests_run++; if ({div_zero, sat} !== {e_dz, e_sat}) begin tests_failed++; $display("FAIL stall flags cyc %0d got %b%b want %b%b", c, div_zero, sat, e_dz, e_sat); end
    end
    release_result(0);
  endtask

  task automatic test_back_to_back();
    int r_n1, r_lat, e_n1, lat;
    bit r_dz, r_sat, r_to, e_dz, e_sat;
    do_op('h18, 30, 30, r_n1, r_dz, r_sat, r_lat, r_to);
    tests_run++;
    if (r_to) begin tests_failed++; $display("FAIL b2b first timeout got no out_valid want out_valid"); end
    model('h10, 30, 90, e_n1, e_dz, e_sat);
    in_valid = 1'b1; n2 = 8'h10; theta1 = 7'd30; theta2 = 7'd90;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b idle in_ready got %b want 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b idle out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b accept in_ready got %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL b2b latency got %0d want %0d", lat, LAT); end
    tests_run++; if (int'(n1) !== e_n1) begin tests_failed++; $display("FAIL b2b n1 got %h want %h", n1, e_n1); end
    release_result(1);
  endtask

  task automatic test_reset_mid_div();
    int r_n1, r_lat, e_n1, seen;
    bit r_dz, r_sat, r_to, e_dz, e_sat;
    in_valid = 1'b1; n2 = 8'h55; theta1 = 7'd40; theta2 = 7'd70;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstdiv in_ready got %b want 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstdiv out_valid got %b want 0", out_valid); end
    tests_run++; if (n1 !== 8'h00) begin tests_failed++; $display("FAIL rstdiv n1 got %h want 00", n1); end
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen++; end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL rstdiv stray out_valid got %0d cycles want 0", seen); end
    model('hF0, 120, 90, e_n1, e_dz, e_sat);
    do_op('hF0, 120, 90, r_n1, r_dz, r_sat, r_lat, r_to);
    tests_run++; if (r_to || r_lat !== LAT) begin tests_failed++; $display("FAIL rstdiv next latency got %0d want %0d", r_lat, LAT); end
    tests_run++; if (r_n1 !== e_n1 || r_sat !== e_sat) begin tests_failed++; $display("FAIL rstdiv next result got %h/%b want %h/%b", r_n1, r_sat, e_n1, e_sat); end
    release_result(0);
  endtask

  task automatic test_random();
    int a, t1, t2, r_n1, r_lat, e_n1;
    bit r_dz, r_sat, r_to, e_dz, e_sat;
    for (int i = 0; i < 40; i++) begin
      a  = int'($urandom_range(0, 255));
      t1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127));
      t2 = int'($urandom_range(0, 127));
      model(a, t1, t2, e_n1, e_dz, e_sat);
      do_op(a, t1, t2, r_n1, r_dz, r_sat, r_lat, r_to);
      tests_run++; if (r_to || r_lat !== LAT) begin tests_failed++; $display("FAIL random %0d latency got %0d want %0d", i, r_lat, LAT); end
      tests_run++; if (r_n1 !== e_n1) begin tests_failed++; $display("FAIL random %0d n1 (n2=%0d t1=%0d t2=%0d) got %h want %h", i, a, t1, t2, r_n1, e_n1); end
      tests_run++; if (r_dz !== e_dz) begin tests_failed++; $display("FAIL random %0d div_zero got %b want %b", i, r_dz, e_dz); end
      tests_run++; if (r_sat !== e_sat) begin tests_failed++; $display("FAIL random %0d sat got %b want %b", i, r_sat, e_sat); end
      release_result(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/snell_index_solver.md
SNELL_INDEX_SOLVER -- requirements
Module: snell_index_solver

Interface
REQ-001 The block SHALL have parameter IDX_W, default 8, total width of n2/n1 in unsigned fixed point.
REQ-002 The block SHALL have parameter IDX_FRAC, default 4, fractional bits of n2/n1.
REQ-003 The block SHALL have parameter ANG_W, default 7, width of angle inputs in unsigned integer degrees.
REQ-004 The block SHALL have parameter SIN_FRAC, default 8, fractional bits of sine values, unsigned Q1.SIN_FRAC.
REQ-005 The block SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- n2  in  IDX_W  refractive index of medium 2
- theta1  in  ANG_W  incidence angle, degrees
- theta2  in  ANG_W  refraction angle, degrees
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- n1  out  IDX_W  computed index of medium 1
- div_zero  out  1  sin(theta1) was zero
- sat  out  1  result saturated

Function
REQ-006 The block SHALL compute n1 = n2*sin(theta2)/sin(theta1) using IDX_FRAC fractional bits, truncating toward zero.
REQ-007 Angles above 90 SHALL be clamped to 90 before lookup.
REQ-008 Sine values SHALL be round(sin(d)*2^SIN_FRAC); sin(90) = 2^SIN_FRAC exactly.
REQ-009 Product P = n2*sin2 SHALL be exact with width PW = IDX_W+SIN_FRAC+1; the quotient P/sin1 directly yields IDX_FRAC fractional bits.
REQ-010 The FSM SHALL use states IDLE, LOOK2, LOOK1, MUL, DIV, DONE.
- IDLE->LOOK2 on in_valid&&in_ready.
- LOOK2->LOOK1->MUL: one cycle each.
- MUL->DIV.
- DIV lasts PW cycles, one restoring-division quotient bit per cycle, MSB first.
- DIV->DONE.
- DONE->IDLE on out_ready.
REQ-011 in_ready SHALL be 1 only in IDLE; operands SHALL be registered on the accept cycle.
REQ-012 out_valid SHALL assert exactly PW+4 cycles after the accept edge (21 at defaults).
REQ-013 n1, div_zero and sat SHALL remain stable while out_valid=1 and out_ready=0.
REQ-014 If the clamped theta1 is 0, then n1 SHALL be all ones and div_zero=1, sat=0; latency SHALL be unchanged.
REQ-015 If the quotient is >= 2^IDX_W, then n1 SHALL be all ones and sat=1.
REQ-016 A new accept SHALL NOT occur on the same cycle as the DONE handshake; IDLE is always visited for at least one cycle.

Reset
REQ-017 While rst=1 at a clk edge, the FSM SHALL enter IDLE, with in_ready=1 and out_valid=0, n1=0, div_zero=0, sat=0 the following cycle.
REQ-018 Reset asserted mid-operation SHALL abandon the computation with no out_valid for it.

Configuration
REQ-019 With macro SNELL_ROUND_EN defined, the divider SHALL compute one extra quotient bit and round half-up, saturating per REQ-015 after rounding; DIV lasts PW+1 cycles and latency is PW+5.
REQ-020 Without SNELL_ROUND_EN, the block SHALL truncate per REQ-006 with latency PW+4.

Structure
REQ-021 A shared package snell_pkg SHALL hold the FSM state enum, the default parameter constants, and the PW/latency derivation functions.
REQ-022 A single sub-module snell_sine_lut SHALL hold a 91-entry table computed at elaboration, with registered output (1-cycle latency), time-shared for theta2 then theta1.

Verification (defaults, truncation build)
REQ-023 n2=0x18, theta1=30, theta2=30 -> n1=0x18, div_zero=0, sat=0, out_valid 21 cycles after accept.
REQ-024 n2=0x10, theta1=30, theta2=90 -> n1=0x20.
REQ-025 n2=0x10, theta1=0, theta2=45 -> n1=0xFF, div_zero=1, sat=0.
REQ-026 n2=0xF0, theta1=30, theta2=90 -> n1=0xFF, sat=1; theta1=120 behaves as theta1=90.
REQ-027 out_ready held 0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; back-to-back in_valid is accepted only after the DONE handshake plus the IDLE cycle.
REQ-028 rst pulsed in DIV -> out_valid stays 0, in_ready=1 next cycle, and a following operation returns the correct result.
